// File: rtl/riscv_lsu_pkg.sv
// ---------------------------------------------------------------------------
// riscv_lsu_pkg
// Shared definitions for the load/store unit:
//   - lsu_state_t   : LSU sequencing states (IDLE / REQ / DONE)
//   - LDST_*        : memory access size codes produced by instruction decode
//   - BE_*          : base byte-enable patterns before lane shifting
//   - byteEnable()  : byte-enable pattern for a size and low address bits
//   - replicateWd() : store data copied into every lane of the bus word
//   - isMisaligned(): natural-alignment check for a size and low address bits
// ---------------------------------------------------------------------------
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Size codes follow the load/store funct3 field; 3, 6 and 7 are unused
    // and are handled as full words everywhere.
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Halfwords only ever sit in lane pair 0 or 2, so addr[0] is ignored.
    function automatic logic [3:0] byteEnable(input logic [2:0] size,
                                              input logic [1:0] addrLo);
        case (size)
            LDST_B, LDST_BU: return BE_B << addrLo;
            LDST_H, LDST_HU: return BE_H << {addrLo[1], 1'b0};
            default:         return BE_W;
        endcase
    endfunction

    // Memory picks the right lane through the byte enables, so the store
    // data is simply copied to every lane it could land in.
    function automatic logic [31:0] replicateWd(input logic [2:0]  size,
                                                input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: return {4{wd[7:0]}};
            LDST_H, LDST_HU: return {2{wd[15:0]}};
            default:         return wd;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] size,
                                          input logic [1:0] addrLo);
        case (size)
            LDST_B, LDST_BU: return 1'b0;
            LDST_H, LDST_HU: return addrLo[0];
            default:         return addrLo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// ---------------------------------------------------------------------------
// riscv_lsu_if
// Data-memory bus between the load/store unit and data memory.
//   mem_req_o   : request, held until mem_ready_i
//   mem_we_o    : 1 = write, 0 = read
//   mem_be_o    : byte enables, one per lane
//   mem_addr_o  : word-aligned byte address (low two bits zero)
//   mem_wd_o    : lane-replicated write data
//   mem_rd_i    : read word returned by memory
//   mem_ready_i : transaction accepted/completed this cycle
// Modports: master = LSU side, slave = memory side.
// ---------------------------------------------------------------------------
interface riscv_lsu_if #(
    parameter int ADDR_W = 32
);

    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wd_o;
    logic [31:0]       mem_rd_i;
    logic              mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );

endinterface

// File: rtl/riscv_lsu_align.sv
// ---------------------------------------------------------------------------
// riscv_lsu_align
// Combinational load-data extraction: picks the addressed byte or halfword
// out of the memory word and sign- or zero-extends it to 32 bits.
//   i_size   : LDST_* size code
//   i_addrLo : low two bits of the byte address
//   i_word   : word read from memory
//   o_data   : extended load result
// ---------------------------------------------------------------------------
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection is done once for both widths; the size code then
    // decides which of the two is extended and how.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_word;

        case (i_addrLo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addrLo[1] ? i_word[31:16] : i_word[15:0];

        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'h000000, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// ---------------------------------------------------------------------------
// riscv_lsu
// Load/store unit: turns one core-side access into a single outstanding,
// byte-enabled word transaction on the data-memory bus and returns the
// extended load data, stalling the core until the transaction completes.
//
// Ports:
//   clk_i, rst_ni   : clock (rising edge), asynchronous active-low reset
//   core_req_i      : access requested, held while core_stall_o = 1
//   core_we_i       : 1 = store, 0 = load
//   core_size_i     : LDST_* size code
//   core_addr_i     : byte address
//   core_wd_i       : store data
//   core_rd_o       : extended load data, valid in DONE and held after
//   core_stall_o    : freeze PC and pipeline
//   lsu_misalign_o  : misaligned access flag (one DONE cycle)
//   mem             : riscv_lsu_if master modport (data-memory bus)
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   - misaligned H/HU/W requests skip the bus, go straight to DONE
//               and raise lsu_misalign_o for that cycle
//   undefined - lsu_misalign_o is tied 0 and misaligned accesses proceed
//               with the low address bits handled by the lane rules
// ---------------------------------------------------------------------------
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              lsu_misalign_o,
    riscv_lsu_if.master       mem
);

    // The lane logic is hard-wired for four byte lanes.
    if (DATA_W != 32) begin : g_dataWCheck
        $error("riscv_lsu: DATA_W must be 32");
    end

    lsu_state_t        r_state;
    logic              r_memReq;
    logic              r_memWe;
    logic [3:0]        r_memBe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memWd;
    logic [2:0]        r_size;
    logic [1:0]        r_addrLo;
    logic [31:0]       r_coreRd;
    logic [31:0]       w_loadData;
`ifdef LSU_MISALIGN_EXC_EN
    logic              r_misalign;
`endif

    // Extraction works on the registered size/offset so it stays consistent
    // with the access that was actually issued, whatever the core does now.
    riscv_lsu_align u_align (
        .i_size   (r_size),
        .i_addrLo (r_addrLo),
        .i_word   (mem.mem_rd_i),
        .o_data   (w_loadData)
    );

    // Single sequencer: IDLE latches the access, REQ holds it on the bus
    // until memory is ready, DONE releases the stall for one cycle.
    // Everything the bus sees is registered so it is stable through REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_memBe   <= 4'b0000;
            r_memAddr <= '0;
            r_memWd   <= 32'h0;
            r_size    <= 3'd0;
            r_addrLo  <= 2'b00;
            r_coreRd  <= 32'h0;
`ifdef LSU_MISALIGN_EXC_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (core_req_i) begin
                        r_memWe   <= core_we_i;
                        r_memBe   <= byteEnable(core_size_i, core_addr_i[1:0]);
                        r_memAddr <= {core_addr_i[ADDR_W-1:2], 2'b00};
                        r_memWd   <= replicateWd(core_size_i, core_wd_i);
                        r_size    <= core_size_i;
                        r_addrLo  <= core_addr_i[1:0];
`ifdef LSU_MISALIGN_EXC_EN
                        if (isMisaligned(core_size_i, core_addr_i[1:0])) begin
                            r_misalign <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_memReq <= 1'b1;
                            r_state  <= REQ;
                        end
`else
                        r_memReq <= 1'b1;
                        r_state  <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (mem.mem_ready_i) begin
                        r_memReq <= 1'b0;
                        if (!r_memWe) begin
                            r_coreRd <= w_loadData;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
`ifdef LSU_MISALIGN_EXC_EN
                    r_misalign <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the core freezes in the same cycle it asks;
    // DONE is the one cycle the pipeline is allowed to move on.
    assign core_stall_o = core_req_i && (r_state != DONE);
    assign core_rd_o    = r_coreRd;

`ifdef LSU_MISALIGN_EXC_EN
    assign lsu_misalign_o = r_misalign;
`else
    assign lsu_misalign_o = 1'b0;
`endif

    assign mem.mem_req_o  = r_memReq;
    assign mem.mem_we_o   = r_memWe;
    assign mem.mem_be_o   = r_memBe;
    assign mem.mem_addr_o = r_memAddr;
    assign mem.mem_wd_o   = r_memWd;

endmodule
